// File: rtl/de_acelp_seq_pkg.sv
// Shared scratch-memory map, bus widths and sequencer state encoding.
// Latency: n/a (constants and a pure helper function).
// Backpressure: n/a.
package de_acelp_seq_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int IDX_W  = 6;

    // Scratch locations shared with de_acelp_pipe. COD is 64-word aligned so
    // the word index can be spliced straight into the low address bits.
    localparam logic [ADDR_W-1:0] INDEX_IN = 12'h000;
    localparam logic [ADDR_W-1:0] SIGN_IN  = 12'h001;
    localparam logic [ADDR_W-1:0] COD      = 12'h100;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_INDEX  = 3'd1,
        WR_SIGN   = 3'd2,
        START     = 3'd3,
        WAIT_DONE = 3'd4,
        RD_ADDR   = 3'd5,
        RD_CAP    = 3'd6,
        OUT       = 3'd7
    } state_t;

    // Read address of codevector word idx.
    function automatic logic [ADDR_W-1:0] cod_addr(input logic [IDX_W-1:0] idx);
        return {COD[ADDR_W-1:IDX_W], idx};
    endfunction

endpackage

// File: rtl/de_acelp_seq_if.sv
// Host, de_acelp_pipe, scratch-memory and codevector stream signals of the sequencer.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on input, cod_valid/cod_ready on output.
interface de_acelp_seq_if;
    import de_acelp_seq_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] index_in;
    logic [DATA_W-1:0] sign_in;
    logic              acelp_start;
    logic              acelp_done;
    logic              mem_sel;
    logic [ADDR_W-1:0] mem_write_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write_en;
    logic [ADDR_W-1:0] mem_read_addr;
    logic [DATA_W-1:0] mem_read_data;
    logic              cod_valid;
    logic              cod_ready;
    logic [DATA_W-1:0] cod_data;
    logic [IDX_W-1:0]  cod_idx;
    logic              cod_last;
    logic              busy;
    logic              err_timeout;

    // Sequencer side.
    modport slave (
        input  in_valid, index_in, sign_in, acelp_done, mem_read_data, cod_ready,
        output in_ready, acelp_start, mem_sel, mem_write_addr, mem_write_data,
               mem_write_en, mem_read_addr, cod_valid, cod_data, cod_idx, cod_last,
               busy, err_timeout
    );

    // Host / environment side.
    modport master (
        output in_valid, index_in, sign_in, acelp_done, mem_read_data, cod_ready,
        input  in_ready, acelp_start, mem_sel, mem_write_addr, mem_write_data,
               mem_write_en, mem_read_addr, cod_valid, cod_data, cod_idx, cod_last,
               busy, err_timeout
    );

endinterface

// File: rtl/de_acelp_seq_watchdog.sv
// Counts enabled cycles since the last clear and flags when LIMIT is reached.
// Latency: o_expire is high in the cycle the count equals LIMIT (LIMIT+1th enabled cycle).
// Backpressure: none; the count holds at LIMIT until cleared.
module seq_watchdog #(
    parameter int LIMIT = 4095
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] r_count;

    // Cycle counter: clear wins, then count while enabled, saturating at LIMIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expire) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = (r_count == CNT_W'(LIMIT));

endmodule

// File: rtl/de_acelp_seq.sv
// Sequences one ACELP subframe: store index/sign, run de_acelp_pipe, stream NUM_COD codevector words.
// Latency: acelp_start 3 cycles after accept; each word takes at least 3 cycles (addr, capture, out).
// Backpressure: in_ready only in IDLE (nothing queued); OUT holds the word until cod_ready.
module de_acelp_seq
    import de_acelp_seq_pkg::*;
#(
    parameter int NUM_COD        = 40,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic          clk,
    input  logic          reset,
    de_acelp_seq_if.slave bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COD - 1);

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_index;
    logic [DATA_W-1:0] r_sign;
    logic [DATA_W-1:0] r_cod_data;
    logic [IDX_W-1:0]  r_idx;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_last;
    logic              w_wd_clear;
    logic              w_wd_enable;
    logic              w_wd_expire;

    assign w_in_fire   = (r_state == IDLE) && bus.in_valid;
    assign w_out_fire  = (r_state == OUT) && bus.cod_ready;
    assign w_last      = (r_idx == LAST_IDX);
    assign w_wd_enable = (r_state == WAIT_DONE);
    assign w_wd_clear  = !w_wd_enable;

    seq_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_wd_clear),
        .i_enable (w_wd_enable),
        .o_expire (w_wd_expire)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; done is only looked at in WAIT_DONE so a level left high
    // from the previous subframe cannot short-circuit START.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (bus.in_valid) w_next = WR_INDEX;
            WR_INDEX:  w_next = WR_SIGN;
            WR_SIGN:   w_next = START;
            START:     w_next = WAIT_DONE;
            WAIT_DONE: begin
                if (bus.acelp_done) begin
                    w_next = RD_ADDR;
                end else if (w_wd_expire) begin
                    w_next = IDLE;
                end
            end
            RD_ADDR:   w_next = RD_CAP;
            RD_CAP:    w_next = OUT;
            OUT:       if (bus.cod_ready) w_next = w_last ? IDLE : RD_ADDR;
            default:   w_next = IDLE;
        endcase
    end

    // Datapath: capture the host words, step the word index, capture read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_index    <= '0;
            r_sign     <= '0;
            r_idx      <= '0;
            r_cod_data <= '0;
        end else begin
            if (w_in_fire) begin
                r_index <= bus.index_in;
                r_sign  <= bus.sign_in;
            end
            if ((r_state == WAIT_DONE) && bus.acelp_done) begin
                r_idx <= '0;
            end else if (w_out_fire && !w_last) begin
                r_idx <= r_idx + 1'b1;
            end
            if (r_state == RD_CAP) begin
                r_cod_data <= bus.mem_read_data;
            end
        end
    end

    // Moore outputs; the sequencer owns the scratch memory except while the pipe runs.
    always_comb begin
        bus.in_ready       = 1'b0;
        bus.busy           = 1'b1;
        bus.mem_sel        = 1'b1;
        bus.acelp_start    = 1'b0;
        bus.mem_write_en   = 1'b0;
        bus.mem_write_addr = '0;
        bus.mem_write_data = '0;
        bus.mem_read_addr  = '0;
        bus.cod_valid      = 1'b0;
        bus.cod_last       = 1'b0;
        bus.err_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
            end
            WR_INDEX: begin
                bus.mem_write_en   = 1'b1;
                bus.mem_write_addr = INDEX_IN;
                bus.mem_write_data = r_index;
            end
            WR_SIGN: begin
                bus.mem_write_en   = 1'b1;
                bus.mem_write_addr = SIGN_IN;
                bus.mem_write_data = r_sign;
            end
            START: begin
                bus.mem_sel     = 1'b0;
                bus.acelp_start = 1'b1;
            end
            WAIT_DONE: begin
                bus.mem_sel     = 1'b0;
                bus.err_timeout = w_wd_expire && !bus.acelp_done;
            end
            RD_ADDR: bus.mem_read_addr = cod_addr(r_idx);
            OUT: begin
                bus.cod_valid = 1'b1;
                bus.cod_last  = w_last;
            end
            default: ;
        endcase
    end

    assign bus.cod_data = r_cod_data;
    assign bus.cod_idx  = r_idx;

endmodule

// File: tb/tb_de_acelp_seq.sv
// Bench for de_acelp_seq: memory + pipe model, codevector scoreboard, table and corner sequences.
// Latency: n/a.
// Backpressure: cod_ready driven by the bench (always, forced stall, or random).
module tb_de_acelp_seq;
    import de_acelp_seq_pkg::*;

    localparam int NUM_COD  = 40;
    localparam int TO_SHORT = 50;

    typedef struct packed {
        logic [31:0] data;
        logic [5:0]  idx;
        logic        last;
    } cod_t;

    typedef struct {
        int          cyc;
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] ix;
        logic [31:0] sg;
        int          delay;
        bit          rnd_ready;
        logic [31:0] exp_first;
        int          exp_words;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    de_acelp_seq_if bus ();
    de_acelp_seq_if bus2 ();

    de_acelp_seq #(.NUM_COD(NUM_COD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    de_acelp_seq #(.NUM_COD(NUM_COD), .TIMEOUT_CYCLES(TO_SHORT)) dut_to (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    cod_t        sb_q[$];
    wr_t         wr_q[$];
    int          start_q[$];
    int          start2_q[$];
    int          err2_q[$];
    int          cod2_cnt   = 0;
    int          cyc        = 0;
    int          words_seen = 0;
    logic [31:0] first_word = '0;
    int          pipe_delay = 10;
    bit          pipe_rand  = 0;
    bit          rand_ready = 0;
    int          stall_word = -1;
    int          stall_cnt  = 0;
    logic [31:0] mem [0:4095];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] gold(input logic [31:0] ix, input logic [31:0] sg, input int k);
        return (ix ^ {sg[15:0], 16'h0000}) + 32'(k) * 32'h00010001;
    endfunction

    task automatic push_subframe(input logic [31:0] ix, input logic [31:0] sg);
        cod_t e;
        for (int k = 0; k < NUM_COD; k++) begin
            e.data = gold(ix, sg, k);
            e.idx  = 6'(k);
            e.last = (k == NUM_COD - 1);
            sb_q.push_back(e);
        end
    endtask

    // Memory (1-cycle read), de_acelp_pipe model, cod_ready driver and stream checker.
    initial begin : monitor
        logic [11:0] prev_raddr;
        logic        prev_stall;
        logic [31:0] held_data;
        logic [5:0]  held_idx;
        int          pipe_cnt;
        cod_t        got;
        cod_t        exp;
        prev_raddr = '0;
        prev_stall = 1'b0;
        held_data  = '0;
        held_idx   = '0;
        pipe_cnt   = 0;
        for (int a = 0; a < 4096; a++) mem[a] = '0;
        bus.acelp_done    = 1'b0;
        bus.mem_read_data = '0;
        bus.cod_ready     = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                pipe_cnt          = 0;
                prev_raddr        = '0;
                prev_stall        = 1'b0;
                bus.acelp_done    = 1'b0;
                bus.mem_read_data = '0;
                bus.cod_ready     = 1'b1;
                check("reset_quiet", {bus.mem_write_en, bus.acelp_start, bus.cod_valid,
                      bus.err_timeout, bus.busy, bus.in_ready, bus.mem_sel}, 64'b0000011);
            end else begin
                bus.mem_read_data = mem[prev_raddr];
                prev_raddr        = bus.mem_read_addr;
                if (bus.mem_write_en) begin
                    check("write_owner", bus.mem_sel, 1);
                    mem[bus.mem_write_addr] = bus.mem_write_data;
                    wr_q.push_back('{cyc, bus.mem_write_addr, bus.mem_write_data});
                end
                if (bus.acelp_start) begin
                    check("start_owner", bus.mem_sel, 0);
                    start_q.push_back(cyc);
                    bus.acelp_done = 1'b0;
                    pipe_cnt = pipe_rand ? int'($urandom_range(1, 20)) : pipe_delay;
                end else if (pipe_cnt > 0) begin
                    pipe_cnt--;
                    if (pipe_cnt == 0) begin
                        check("pipe_owns_mem", bus.mem_sel, 0);
                        for (int k = 0; k < NUM_COD; k++)
                            mem[COD + 12'(k)] = gold(mem[INDEX_IN], mem[SIGN_IN], k);
                        bus.acelp_done = 1'b1;
                    end
                end
                if (bus.cod_valid && (int'(bus.cod_idx) == stall_word) && (stall_cnt < 5)) begin
                    bus.cod_ready = 1'b0;
                    stall_cnt++;
                end else if (rand_ready) begin
                    bus.cod_ready = ($urandom_range(0, 3) != 0);
                end else begin
                    bus.cod_ready = 1'b1;
                end
                if (prev_stall)
                    check("stall_hold", {bus.cod_valid, bus.cod_data, bus.cod_idx, bus.mem_read_addr},
                          {1'b1, held_data, held_idx, 12'h000});
                if (bus.cod_valid && bus.cod_ready) begin
                    words_seen++;
                    got.data = bus.cod_data;
                    got.idx  = bus.cod_idx;
                    got.last = bus.cod_last;
                    if (bus.cod_idx == 6'd0) first_word = bus.cod_data;
                    if (sb_q.size() == 0) begin
                        check("cod_unexpected", 64'(got), 64'h0);
                    end else begin
                        exp = sb_q.pop_front();
                        check("cod_word", 64'(got), 64'(exp));
                    end
                end
                prev_stall = bus.cod_valid && !bus.cod_ready;
                held_data  = bus.cod_data;
                held_idx   = bus.cod_idx;
                check("ready_vs_busy", bus.in_ready, !bus.busy);
            end
        end
    end

    // Event log for the short-timeout instance.
    initial begin : monitor_to
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus2.acelp_start) start2_q.push_back(cyc);
                if (bus2.err_timeout) err2_q.push_back(cyc);
                if (bus2.cod_valid)   cod2_cnt++;
            end
        end
    end

    initial begin : global_guard
        #2000000;
        $display("FAIL global_timeout: got sim time %0t, want end before it", $time);
        $fatal(1, "bench did not finish");
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 1);
        check({tag, "_mem_sel"}, bus.mem_sel, 1);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_ctl"}, {bus.acelp_start, bus.mem_write_en, bus.cod_valid, bus.cod_last,
              bus.err_timeout, bus.cod_idx, bus.mem_write_addr, bus.mem_read_addr}, 64'h0);
        check({tag, "_data"}, {bus.mem_write_data, bus.cod_data}, 64'h0);
    endtask

    task automatic send(input logic [31:0] ix, input logic [31:0] sg);
        int t;
        @(negedge clk);
        bus.index_in = ix;
        bus.sign_in  = sg;
        bus.in_valid = 1'b1;
        t = 0;
        while (!bus.in_ready && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check("send_accept", bus.in_ready, 1);
        push_subframe(ix, sg);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            #1;
            t++;
        end while ((sb_q.size() != 0 || bus.busy) && t < budget);
        check(name, {sb_q.size() == 0, !bus.busy}, 2'b11);
    endtask

    initial begin : main
        vec_t        vecs[5];
        int          ws;
        int          n;
        int          t;
        logic [31:0] ix;
        logic [31:0] sg;

        vecs[0] = '{32'h0000_0000, 32'h0000_0000,  1, 1'b0, 32'h0000_0000, 40};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_FFFF,  3, 1'b0, 32'h0000_FFFF, 40};
        vecs[2] = '{32'h1234_5678, 32'h0000_00F0, 10, 1'b1, 32'h12C4_5678, 40};
        vecs[3] = '{32'hDEAD_BEEF, 32'hA5A5_0001,  2, 1'b0, 32'hDEAC_BEEF, 40};
        vecs[4] = '{32'h0000_0FFF, 32'h8000_8000, 50, 1'b1, 32'h8000_0FFF, 40};

        bus.in_valid        = 1'b0;
        bus.index_in        = '0;
        bus.sign_in         = '0;
        bus2.in_valid       = 1'b0;
        bus2.index_in       = '0;
        bus2.sign_in        = '0;
        bus2.acelp_done     = 1'b0;
        bus2.mem_read_data  = '0;
        bus2.cod_ready      = 1'b1;

        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst0");
        @(negedge clk) reset = 1'b0;

        // Single subframe: write order, start pulse, 200-cycle pipe, stall on word 7.
        wr_q.delete();
        start_q.delete();
        ws         = words_seen;
        pipe_delay = 200;
        stall_word = 7;
        send(32'h0000_1A2B, 32'h0000_000A);
        wait_idle("tA_complete", 2000);
        stall_word = -1;
        check("tA_writes", wr_q.size(), 2);
        check("tA_starts", start_q.size(), 1);
        check("tA_words", words_seen - ws, 40);
        check("tA_stall_cycles", stall_cnt, 5);
        if (wr_q.size() == 2 && start_q.size() == 1) begin
            check("tA_wr_index", {wr_q[0].addr, wr_q[0].data}, {INDEX_IN, 32'h0000_1A2B});
            check("tA_wr_sign", {wr_q[1].addr, wr_q[1].data}, {SIGN_IN, 32'h0000_000A});
            check("tA_wr_consec", wr_q[1].cyc - wr_q[0].cyc, 1);
            check("tA_start_next", start_q[0] - wr_q[1].cyc, 1);
        end

        // Table of subframes with different words, pipe delays and ready patterns.
        for (int v = 0; v < 5; v++) begin
            wr_q.delete();
            start_q.delete();
            ws         = words_seen;
            pipe_delay = vecs[v].delay;
            rand_ready = vecs[v].rnd_ready;
            send(vecs[v].ix, vecs[v].sg);
            wait_idle($sformatf("vec%0d_complete", v), 2000);
            check($sformatf("vec%0d_words", v), words_seen - ws, vecs[v].exp_words);
            check($sformatf("vec%0d_first", v), first_word, vecs[v].exp_first);
            check($sformatf("vec%0d_writes", v), wr_q.size(), 2);
            check($sformatf("vec%0d_starts", v), start_q.size(), 1);
        end
        rand_ready = 1'b0;

        // Watchdog expiry on the short-timeout instance.
        @(negedge clk);
        bus2.index_in = 32'h0000_0055;
        bus2.sign_in  = 32'h0000_0003;
        bus2.in_valid = 1'b1;
        @(posedge clk);
        #1 bus2.in_valid = 1'b0;
        repeat (80) @(negedge clk);
        #1;
        check("to_starts", start2_q.size(), 1);
        check("to_pulses", err2_q.size(), 1);
        if (start2_q.size() == 1 && err2_q.size() == 1)
            check("to_delay", err2_q[0] - start2_q[0], 51);
        check("to_no_cod", cod2_cnt, 0);
        check("to_idle", {bus2.busy, bus2.in_ready}, 2'b01);

        // Reset while the pipe is running, then a clean subframe.
        pipe_delay = 1000;
        send(32'h0BAD_F00D, 32'h0000_1234);
        repeat (30) @(negedge clk);
        check("rst_in_wait", {bus.busy, bus.mem_sel}, 2'b10);
        @(posedge clk);
        #1 reset = 1'b1;
        wr_q.delete();
        start_q.delete();
        ws = words_seen;
        repeat (5) @(negedge clk);
        check_reset_outputs("rst1");
        sb_q.delete();
        @(negedge clk) reset = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("rst_no_activity", wr_q.size() + start_q.size() + (words_seen - ws), 0);
        check_reset_outputs("rst1_after");
        pipe_delay = 20;
        ws = words_seen;
        send(32'h0000_7777, 32'h0000_0101);
        wait_idle("rst_next_complete", 2000);
        check("rst_next_words", words_seen - ws, 40);

        // 60 back-to-back subframes with in_valid held high.
        ws         = words_seen;
        pipe_rand  = 1'b1;
        rand_ready = 1'b1;
        @(negedge clk);
        ix = $urandom;
        sg = $urandom;
        bus.index_in = ix;
        bus.sign_in  = sg;
        bus.in_valid = 1'b1;
        n = 0;
        t = 0;
        while (n < 60 && t < 40000) begin
            if (bus.in_ready) begin
                push_subframe(ix, sg);
                n++;
                @(posedge clk);
                #1;
                ix = $urandom;
                sg = $urandom;
                bus.index_in = ix;
                bus.sign_in  = sg;
            end
            @(negedge clk);
            t++;
        end
        bus.in_valid = 1'b0;
        check("b2b_accepted", n, 60);
        wait_idle("b2b_complete", 2000);
        check("b2b_words", words_seen - ws, 60 * 40);
        pipe_rand  = 1'b0;
        rand_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/de_acelp_seq.md
DE_ACELP_SEQ -- requirements
Module: de_acelp_seq

Interface
REQ-001 Parameter NUM_COD, default 40: codevector words read back per subframe (1..64).
REQ-002 Parameter TIMEOUT_CYCLES, default 4095: maximum cycles to wait for acelp_done after start.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  host offers one subframe's index/sign pair.
REQ-006 in_ready  output  1  sequencer accepts the pair; high only in IDLE.
REQ-007 index_in  input  32  ACELP pulse-position index word.
REQ-008 sign_in  input  32  ACELP pulse-sign word.
REQ-009 acelp_start  output  1  start pulse to de_acelp_pipe.
REQ-010 acelp_done  input  1  completion level from de_acelp_pipe.
REQ-011 mem_sel  output  1  scratch-memory owner: 1 = sequencer, 0 = de_acelp_pipe; drives all four memory mux selects.
REQ-012 mem_write_addr  output  12  scratch write address.
REQ-013 mem_write_data  output  32  scratch write data.
REQ-014 mem_write_en  output  1  scratch write strobe.
REQ-015 mem_read_addr  output  12  scratch read address.
REQ-016 mem_read_data  input  32  scratch read data, valid exactly 1 cycle after mem_read_addr.
REQ-017 cod_valid / cod_ready  output / input  1 / 1  codevector stream handshake.
REQ-018 cod_data  output  32  codevector word; cod_idx  output  6  word index; cod_last  output  1  marks word NUM_COD-1.
REQ-019 busy  output  1  high in every state except IDLE; err_timeout  output  1  one-cycle pulse on watchdog expiry.

Function
REQ-020 The FSM SHALL have states IDLE, WR_INDEX, WR_SIGN, START, WAIT_DONE, RD_ADDR, RD_CAP and OUT.
REQ-021 On in_valid && in_ready in IDLE, the block SHALL register index_in and sign_in and enter WR_INDEX.
REQ-022 WR_INDEX SHALL assert mem_write_en with addr INDEX_IN and data the registered index for exactly one cycle, then enter WR_SIGN.
REQ-023 WR_SIGN SHALL do the same with SIGN_IN and the registered sign, then enter START.
REQ-024 START SHALL drive mem_sel=0 and assert acelp_start for exactly one cycle; acelp_done SHALL be ignored in START.
REQ-025 WAIT_DONE SHALL hold mem_sel=0 and count cycles, entering RD_ADDR with i=0 on the first cycle acelp_done=1.
REQ-026 If the count reaches TIMEOUT_CYCLES without done, the block SHALL pulse err_timeout, emit no cod words, and return to IDLE.
REQ-027 RD_ADDR SHALL drive mem_read_addr = {COD[11:6], i[5:0]} and enter RD_CAP; RD_CAP SHALL register mem_read_data into cod_data and enter OUT.
REQ-028 OUT SHALL hold cod_valid=1 with stable cod_data, cod_idx=i and cod_last=(i==NUM_COD-1) until cod_ready=1.
REQ-029 On handshake in OUT, the block SHALL increment i and enter RD_ADDR, or enter IDLE if i==NUM_COD-1; minimum word period is 3 cycles.
REQ-030 mem_sel SHALL be 1 in IDLE, WR_*, RD_ADDR, RD_CAP and OUT, and 0 only in START and WAIT_DONE.
REQ-031 mem_write_en SHALL be 0 outside WR_INDEX and WR_SIGN; acelp_start SHALL be 0 outside START.
REQ-032 in_valid SHALL be ignored while busy=1; new input is not queued.

Reset
REQ-033 On reset, the FSM SHALL enter IDLE; the counters, i and registered words SHALL clear to 0; outputs SHALL be in_ready=1, mem_sel=1, busy=0, with every other output 0.
REQ-034 Reset asserted mid-operation (including WAIT_DONE or OUT) SHALL abort the subframe at once with no further writes, start or cod words.

Structure
REQ-035 Scratch addresses INDEX_IN, SIGN_IN and COD, ADDR_W=12, DATA_W=32 and the state encoding SHALL reside in the shared parameter package (paramList).
REQ-036 The block SHALL be a single FSM module; the watchdog counter SHALL be a named sub-module seq_watchdog (clear, enable, expire).

Verification
REQ-037 index=0x00001A2B, sign=0x0000000A: one write each to INDEX_IN then SIGN_IN on consecutive cycles, then a single-cycle acelp_start.
REQ-038 done after 200 cycles, memory model preloaded: 40 words, cod_idx 0..39, data matches COD+i, cod_last only on word 39.
REQ-039 cod_ready low for 5 cycles on word 7: cod_valid and cod_data are held stable; no read address advances.
REQ-040 acelp_done never rises, TIMEOUT_CYCLES=50: err_timeout pulses once, 51 cycles after start; no cod_valid; busy=0.
REQ-041 Reset asserted during WAIT_DONE, then released: all outputs return to reset values, and the next subframe completes correctly.
REQ-042 60 back-to-back subframes with in_valid held high: in_ready is high only in IDLE, and 60×40 words match the golden file.
